// File: rtl/integrator_ctrl_pkg.sv
// Shared types and constants for the threshold_integrator sequencing/safety controller.
// The optional setup watchdog is enabled with the INTEGRATOR_CTRL_WATCHDOG_EN macro.
package integrator_ctrl_pkg;

    // Enum values double as the status codes seen by software.
    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_RESET_INTEG = 3'd1,
        ST_WAIT_SETUP  = 3'd2,
        ST_MONITOR     = 3'd3,
        ST_TRIPPED     = 3'd4
    } ctrl_state_t;

    localparam logic [2:0] FAULT_NONE           = 3'd0;
    localparam logic [2:0] FAULT_BAD_WINDOW     = 3'd1;
    localparam logic [2:0] FAULT_SETUP_TIMEOUT  = 3'd2;
    localparam logic [2:0] FAULT_OVER_THRESHOLD = 3'd3;
    localparam logic [2:0] FAULT_FIFO_OVERFLOW  = 3'd4;
    localparam logic [2:0] FAULT_FIFO_UNDERFLOW = 3'd5;

    // Smallest acceptable window is 2**MIN_WINDOW_BIT samples.
    localparam int MIN_WINDOW_BIT = 11;

    typedef struct packed {
        logic integ_rst;
        logic integ_enable;
        logic armed;
        logic shutdown;
    } ctrl_outputs_t;

    function automatic ctrl_outputs_t decode_outputs(input ctrl_state_t s);
        ctrl_outputs_t o;
        o.integ_rst    = (s == ST_IDLE) || (s == ST_RESET_INTEG);
        o.integ_enable = (s == ST_WAIT_SETUP) || (s == ST_MONITOR);
        o.armed        = (s == ST_MONITOR);
        o.shutdown     = (s == ST_TRIPPED);
        return o;
    endfunction

    // Integrator flag priority: overflow, then underflow, then over-threshold.
    function automatic logic [2:0] flag_fault(input logic ovf, input logic unf, input logic ovt);
        if (ovf)      return FAULT_FIFO_OVERFLOW;
        else if (unf) return FAULT_FIFO_UNDERFLOW;
        else if (ovt) return FAULT_OVER_THRESHOLD;
        else          return FAULT_NONE;
    endfunction

endpackage

// File: rtl/integrator_safety_ctrl_counter.sv
// Loadable down-counter with a zero flag, shared by the reset pulse and setup watchdog.
module ctrl_down_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - WIDTH'(1);
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/integrator_safety_ctrl.sv
// Sequencing and safety controller for threshold_integrator.
// Define INTEGRATOR_CTRL_WATCHDOG_EN to trip on a missing setup_done after SETUP_TIMEOUT cycles.
module integrator_safety_ctrl
    import integrator_ctrl_pkg::*;
#(
    parameter int RESET_PULSE   = 8,
    parameter int SETUP_TIMEOUT = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        arm,
    input  logic        disarm,
    input  logic        clear_fault,
    input  logic [31:0] window_cfg,
    input  logic [14:0] threshold_cfg,
    input  logic        setup_done,
    input  logic        over_threshold,
    input  logic        err_overflow,
    input  logic        err_underflow,
    output logic        integ_rst,
    output logic        integ_enable,
    output logic [31:0] window,
    output logic [14:0] threshold_average,
    output logic        shutdown,
    output logic        armed,
    output logic [2:0]  status,
    output logic [2:0]  fault_code
);

    localparam logic [31:0] RESET_LOAD   = 32'(RESET_PULSE - 1);
    localparam logic [31:0] TIMEOUT_LOAD = 32'(SETUP_TIMEOUT - 1);

    ctrl_state_t   state_reg, state_next;
    logic [2:0]    fault_code_reg, fault_code_next;
    logic [31:0]   window_reg;
    logic [14:0]   threshold_reg;
    ctrl_outputs_t outs_reg;
    logic          latch_cfg;
    logic          cnt_load;
    logic [31:0]   cnt_load_value;
    logic          cnt_dec;
    logic          cnt_zero;
    logic [2:0]    flag_code;

    ctrl_down_counter #(
        .WIDTH(32)
    ) u_counter (
        .clk       (clk),
        .srst      (rst),
        .load      (cnt_load),
        .load_value(cnt_load_value),
        .dec       (cnt_dec),
        .zero      (cnt_zero)
    );

    assign flag_code = flag_fault(err_overflow, err_underflow, over_threshold);

    always_comb begin
        state_next      = state_reg;
        fault_code_next = fault_code_reg;
        latch_cfg       = 1'b0;
        cnt_load        = 1'b0;
        cnt_load_value  = '0;
        cnt_dec         = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (arm && !disarm) begin
                    if (window_cfg[31:MIN_WINDOW_BIT] != '0) begin
                        latch_cfg      = 1'b1;
                        cnt_load       = 1'b1;
                        cnt_load_value = RESET_LOAD;
                        state_next     = ST_RESET_INTEG;
                    end else begin
                        fault_code_next = FAULT_BAD_WINDOW;
                        state_next      = ST_TRIPPED;
                    end
                end
            end
            ST_RESET_INTEG: begin
                if (disarm) begin
                    state_next = ST_IDLE;
                end else if (cnt_zero) begin
                    // The watchdog period starts on entry to WAIT_SETUP.
                    cnt_load       = 1'b1;
                    cnt_load_value = TIMEOUT_LOAD;
                    state_next     = ST_WAIT_SETUP;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_WAIT_SETUP: begin
                cnt_dec = 1'b1;
                if (flag_code != FAULT_NONE) begin
                    fault_code_next = flag_code;
                    state_next      = ST_TRIPPED;
`ifdef INTEGRATOR_CTRL_WATCHDOG_EN
                end else if (cnt_zero && !setup_done) begin
                    fault_code_next = FAULT_SETUP_TIMEOUT;
                    state_next      = ST_TRIPPED;
`endif
                end else if (disarm) begin
                    state_next = ST_IDLE;
                end else if (setup_done) begin
                    state_next = ST_MONITOR;
                end
            end
            ST_MONITOR: begin
                if (flag_code != FAULT_NONE) begin
                    fault_code_next = flag_code;
                    state_next      = ST_TRIPPED;
                end else if (disarm) begin
                    state_next = ST_IDLE;
                end
            end
            ST_TRIPPED: begin
                if (clear_fault) begin
                    fault_code_next = FAULT_NONE;
                    state_next      = ST_IDLE;
                end
            end
            default: begin
                fault_code_next = FAULT_NONE;
                state_next      = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet change with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            fault_code_reg <= FAULT_NONE;
            window_reg     <= '0;
            threshold_reg  <= '0;
            outs_reg       <= decode_outputs(ST_IDLE);
        end else begin
            state_reg      <= state_next;
            fault_code_reg <= fault_code_next;
            outs_reg       <= decode_outputs(state_next);
            if (latch_cfg) begin
                window_reg    <= window_cfg;
                threshold_reg <= threshold_cfg;
            end
        end
    end

    assign integ_rst         = outs_reg.integ_rst;
    assign integ_enable      = outs_reg.integ_enable;
    assign armed             = outs_reg.armed;
    assign shutdown          = outs_reg.shutdown;
    assign window            = window_reg;
    assign threshold_average = threshold_reg;
    assign status            = state_reg;
    assign fault_code        = fault_code_reg;

endmodule

// File: tb/tb_integrator_safety_ctrl.sv
// Self-checking bench for integrator_safety_ctrl: behavioural model plus directed literal checks.
// Honours INTEGRATOR_CTRL_WATCHDOG_EN in the same way as the design.
module tb_integrator_safety_ctrl;

    localparam int RP = 8;
    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arm = 1'b0;
    logic        disarm = 1'b0;
    logic        clear_fault = 1'b0;
    logic [31:0] window_cfg = '0;
    logic [14:0] threshold_cfg = '0;
    logic        setup_done = 1'b0;
    logic        over_threshold = 1'b0;
    logic        err_overflow = 1'b0;
    logic        err_underflow = 1'b0;
    logic        integ_rst, integ_enable, shutdown, armed;
    logic [31:0] window;
    logic [14:0] threshold_average;
    logic [2:0]  status, fault_code;

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    integrator_safety_ctrl #(
        .RESET_PULSE  (RP),
        .SETUP_TIMEOUT(TO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .arm              (arm),
        .disarm           (disarm),
        .clear_fault      (clear_fault),
        .window_cfg       (window_cfg),
        .threshold_cfg    (threshold_cfg),
        .setup_done       (setup_done),
        .over_threshold   (over_threshold),
        .err_overflow     (err_overflow),
        .err_underflow    (err_underflow),
        .integ_rst        (integ_rst),
        .integ_enable     (integ_enable),
        .window           (window),
        .threshold_average(threshold_average),
        .shutdown         (shutdown),
        .armed            (armed),
        .status           (status),
        .fault_code       (fault_code)
    );

    always #5 clk = ~clk;

    // Behavioural model: mode 0..4 follows the state names, timing tracked as elapsed cycles.
    int          m_mode = 0;
    int          m_cycles = 0;
    int          m_fault = 0;
    logic [31:0] m_window = '0;
    logic [14:0] m_thr = '0;

    function automatic int flag_cause(input logic ovf, input logic unf, input logic ovt);
        if (ovf) return 4;
        if (unf) return 5;
        if (ovt) return 3;
        return 0;
    endfunction

    always @(posedge clk) begin
        int cause;
        cause = flag_cause(err_overflow, err_underflow, over_threshold);
        if (rst) begin
            m_mode = 0; m_cycles = 0; m_fault = 0; m_window = '0; m_thr = '0;
        end else begin
            case (m_mode)
                0: if (arm && !disarm) begin
                    if (window_cfg >= 32'd2048) begin
                        m_window = window_cfg; m_thr = threshold_cfg;
                        m_mode = 1; m_cycles = 0;
                    end else begin
                        m_fault = 1; m_mode = 4;
                    end
                end
                1: begin
                    m_cycles++;
                    if (disarm) m_mode = 0;
                    else if (m_cycles == RP) begin m_mode = 2; m_cycles = 0; end
                end
                2: begin
                    m_cycles++;
                    if (cause != 0) begin m_fault = cause; m_mode = 4; end
`ifdef INTEGRATOR_CTRL_WATCHDOG_EN
                    else if (m_cycles == TO && !setup_done) begin m_fault = 2; m_mode = 4; end
`endif
                    else if (disarm) m_mode = 0;
                    else if (setup_done) m_mode = 3;
                end
                3: begin
                    if (cause != 0) begin m_fault = cause; m_mode = 4; end
                    else if (disarm) m_mode = 0;
                end
                4: if (clear_fault) begin m_fault = 0; m_mode = 0; end
                default: m_mode = 0;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (check_en) begin
            check("m_status",     32'(status),            32'(m_mode));
            check("m_integ_rst",  32'(integ_rst),         32'(m_mode == 0 || m_mode == 1));
            check("m_integ_en",   32'(integ_enable),      32'(m_mode == 2 || m_mode == 3));
            check("m_armed",      32'(armed),             32'(m_mode == 3));
            check("m_shutdown",   32'(shutdown),          32'(m_mode == 4));
            check("m_fault_code", 32'(fault_code),        32'(m_fault));
            check("m_window",     window,                 m_window);
            check("m_threshold",  32'(threshold_average), 32'(m_thr));
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_enable();
        int n = 0;
        while (!integ_enable && n < 50) begin step(); n++; end
        check("enable_rise", 32'(integ_enable), 32'd1);
    endtask

    task automatic go_monitor(input logic [31:0] w, input logic [14:0] t);
        window_cfg = w; threshold_cfg = t; arm = 1'b1;
        step();
        arm = 1'b0;
        wait_enable();
        setup_done = 1'b1;
        step();
        setup_done = 1'b0;
        check("armed_after_setup", 32'(armed), 32'd1);
    endtask

    initial begin
        int hi;
        int wd;
        rst = 1'b1;
        step();
        check_en = 1'b1;
        step();
        check("reset_integ_rst", 32'(integ_rst), 32'd1);
        check("reset_status", 32'(status), 32'd0);
        check("reset_window", window, 32'd0);
        check("reset_fault", 32'(fault_code), 32'd0);
        rst = 1'b0;
        step();

        // Nominal arm: 8-cycle reset pulse, then enable, then armed one cycle after setup_done.
        window_cfg = 32'd4096; threshold_cfg = 15'd100; arm = 1'b1;
        step();
        arm = 1'b0;
        check("nom_window", window, 32'd4096);
        check("nom_threshold", 32'(threshold_average), 32'd100);
        hi = 0;
        while (integ_rst && hi < 50) begin hi++; step(); end
        check("nom_rst_pulse_len", 32'(hi), 32'd8);
        check("nom_enable", 32'(integ_enable), 32'd1);
        check("nom_status_wait", 32'(status), 32'd2);
        setup_done = 1'b1;
        step();
        setup_done = 1'b0;
        check("nom_armed", 32'(armed), 32'd1);

        // Config change while armed has no effect.
        window_cfg = 32'd8192; threshold_cfg = 15'd7;
        step(); step();
        check("cfg_hold_window", window, 32'd4096);
        check("cfg_hold_thr", 32'(threshold_average), 32'd100);

        // Underflow beats over-threshold; then clear with a same-cycle arm that is ignored.
        err_underflow = 1'b1; over_threshold = 1'b1;
        step();
        err_underflow = 1'b0; over_threshold = 1'b0;
        check("prio_fault", 32'(fault_code), 32'd5);
        check("prio_shutdown", 32'(shutdown), 32'd1);
        check("prio_enable", 32'(integ_enable), 32'd0);
        clear_fault = 1'b1; arm = 1'b1;
        step();
        clear_fault = 1'b0; arm = 1'b0;
        check("clear_status", 32'(status), 32'd0);
        check("clear_fault", 32'(fault_code), 32'd0);
        check("clear_shutdown", 32'(shutdown), 32'd0);
        step();
        check("clear_arm_ignored", 32'(status), 32'd0);

        // Disarm with overflow in the same cycle: fault wins.
        go_monitor(32'd4096, 15'd50);
        disarm = 1'b1; err_overflow = 1'b1;
        step();
        disarm = 1'b0; err_overflow = 1'b0;
        check("dis_vs_fault_status", 32'(status), 32'd4);
        check("dis_vs_fault_code", 32'(fault_code), 32'd4);
        clear_fault = 1'b1;
        step();
        clear_fault = 1'b0;

        // Plain disarm in MONITOR.
        go_monitor(32'd65536, 15'd12);
        disarm = 1'b1;
        step();
        disarm = 1'b0;
        check("disarm_status", 32'(status), 32'd0);
        check("disarm_integ_rst", 32'(integ_rst), 32'd1);
        check("disarm_enable", 32'(integ_enable), 32'd0);

        // Bad window (just below the minimum) trips immediately.
        window_cfg = 32'd2047; arm = 1'b1;
        step();
        arm = 1'b0;
        check("badwin_status", 32'(status), 32'd4);
        check("badwin_fault", 32'(fault_code), 32'd1);
        check("badwin_shutdown", 32'(shutdown), 32'd1);
        step(); step();
        check("badwin_no_enable", 32'(integ_enable), 32'd0);
        // Reset while tripped clears the fault.
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_trip_fault", 32'(fault_code), 32'd0);
        check("rst_trip_shutdown", 32'(shutdown), 32'd0);

        // Minimum legal window is accepted; disarm during the reset pulse.
        window_cfg = 32'd2048; arm = 1'b1;
        step();
        arm = 1'b0;
        check("minwin_status", 32'(status), 32'd1);
        disarm = 1'b1;
        step();
        disarm = 1'b0;
        check("minwin_disarm", 32'(status), 32'd0);

        // Setup watchdog.
        window_cfg = 32'd4096; arm = 1'b1;
        step();
        arm = 1'b0;
        wait_enable();
`ifdef INTEGRATOR_CTRL_WATCHDOG_EN
        wd = 0;
        while (status == 3'd2 && wd < 20000) begin wd++; step(); end
        check("wd_cycles", 32'(wd), 32'd100);
        check("wd_fault", 32'(fault_code), 32'd2);
        clear_fault = 1'b1;
        step();
        clear_fault = 1'b0;
`else
        wd = 0;
        for (int i = 0; i < 10000; i++) begin
            if (status == 3'd2) wd++;
            step();
        end
        check("nowd_cycles", 32'(wd), 32'd10000);
        check("nowd_status", 32'(status), 32'd2);
        disarm = 1'b1;
        step();
        disarm = 1'b0;
`endif

        // Mid-operation reset from MONITOR.
        go_monitor(32'd4096, 15'd300);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_integ_rst", 32'(integ_rst), 32'd1);
        check("midrst_enable", 32'(integ_enable), 32'd0);
        check("midrst_armed", 32'(armed), 32'd0);
        check("midrst_window", window, 32'd0);
        check("midrst_status", 32'(status), 32'd0);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/integrator_safety_ctrl.md
# integrator_safety_ctrl

Sequencing and safety controller for `threshold_integrator`. It validates and latches the window/threshold configuration, then holds the integrator in reset for a guaranteed minimum pulse. It enables the integrator, waits for its `setup_done`, and monitors its error and over-threshold flags. Any fault latches a sticky `shutdown` request and a fault code until software clears it.

## Interface
Parameters:
- `RESET_PULSE`, 8: minimum cycles `integ_rst` is held high after an arm request (≥2).
- `SETUP_TIMEOUT`, 1_000_000: watchdog limit in cycles for `setup_done`. Used only with the watchdog compiled in.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `arm`  in  1  level; start request, sampled in IDLE.
- `disarm`  in  1  level; abort request.
- `clear_fault`  in  1  level; leave TRIPPED.
- `window_cfg`  in  32  requested window, in samples.
- `threshold_cfg`  in  15  requested threshold average.
- `setup_done`  in  1  from integrator.
- `over_threshold`, `err_overflow`, `err_underflow`  in  1 each  from integrator.
- `integ_rst`  out  1  integrator reset.
- `integ_enable`  out  1  integrator enable.
- `window`  out  32  latched window.
- `threshold_average`  out  15  latched threshold.
- `shutdown`  out  1  sticky shutdown request.
- `armed`  out  1  high only in MONITOR.
- `status`  out  3  current state code.
- `fault_code`  out  3  latched cause.

## Operation
- States, with `status` codes: IDLE=0, RESET_INTEG=1, WAIT_SETUP=2, MONITOR=3, TRIPPED=4.
- `fault_code` values: 0 none, 1 bad window, 2 setup timeout, 3 over threshold, 4 FIFO overflow, 5 FIFO underflow.
- **IDLE**
  - `integ_rst`=1 and `integ_enable`=0.
  - On `arm` && !`disarm`:
    - If `window_cfg[31:11]` != 0: latch `window` and `threshold_average`, load the counter with `RESET_PULSE`-1, go to RESET_INTEG.
    - Otherwise: fault 1, go to TRIPPED.
- **RESET_INTEG**
  - `integ_rst`=1 while the counter decrements.
  - At 0: go to WAIT_SETUP.
- **WAIT_SETUP**
  - `integ_rst`=0 and `integ_enable`=1.
  - `setup_done` → MONITOR.
- **MONITOR**
  - `integ_enable`=1 and `armed`=1.
- **Fault checking** in WAIT_SETUP and MONITOR. Priority: `err_overflow` (4) > `err_underflow` (5) > `over_threshold` (3). Any of them sends the block to TRIPPED.
- **Disarm**: `disarm` in RESET_INTEG, WAIT_SETUP or MONITOR returns the block to IDLE. A fault in the same cycle wins over `disarm`.
- **TRIPPED**
  - `shutdown`=1, `integ_enable`=0.
  - `integ_rst`=0, so the integrator's flags are preserved for readout.
  - `arm` and `disarm` are ignored.
  - `clear_fault` → IDLE, with `fault_code`=0 and `shutdown`=0. `arm` asserted in that same cycle is ignored.
- **Configuration inputs** are latched only on the IDLE→RESET_INTEG transition. Later changes have no effect until the next arm.
- **Reset**: state=IDLE, `integ_rst`=1, `integ_enable`=0, `window`=0, `threshold_average`=0, `shutdown`=0, `armed`=0, `status`=0, `fault_code`=0, counter=0.
  - Reset while in TRIPPED clears the fault.
  - Reset while in MONITOR immediately re-asserts `integ_rst`.

## Timing
- All outputs are registered and driven from the current state/registers.
- Arm sampled in cycle N:
  - `window` is valid at N+1.
  - `integ_rst` stays high through N+`RESET_PULSE`.
  - `integ_rst` falls and `integ_enable` rises together at N+`RESET_PULSE`+1. The window is therefore stable ≥`RESET_PULSE` cycles before enable.
- `setup_done` high in cycle M → `armed`=1 at M+1.
- Fault input high in cycle F → `shutdown`=1, `fault_code` valid and `integ_enable`=0 at F+1. Worst-case latency is 1 cycle.
- Disarm in cycle D → `integ_enable`=0 and `integ_rst`=1 at D+1.

## Configuration
- `INTEGRATOR_CTRL_WATCHDOG_EN` defined:
  - WAIT_SETUP reloads the counter with `SETUP_TIMEOUT`-1 on entry.
  - Reaching 0 without `setup_done` → TRIPPED with fault 2.
  - `setup_done` in the cycle the counter reaches 0 wins, and the block goes to MONITOR.
- Not defined:
  - WAIT_SETUP waits indefinitely.
  - Fault 2 is never produced and `SETUP_TIMEOUT` is unused.

## Structure
- Package `integrator_ctrl_pkg` holds:
  - the state enum and `status` codes;
  - the `fault_code` localparams;
  - `MIN_WINDOW_BIT`=11.
- Sub-module `ctrl_down_counter` is a loadable 32-bit down-counter with a zero flag. It is shared by the reset pulse and the watchdog, which are never active simultaneously.

## Test plan
- Nominal arm: `window_cfg`=4096, `threshold_cfg`=100, `arm` pulse → `integ_rst` high for 8 cycles; `integ_enable` rises at N+9; `setup_done` at M → `armed`=1 at M+1; `window`=4096.
- Bad window: `window_cfg`=2047 with `arm` → `status`=4, `fault_code`=1, `shutdown`=1 next cycle; `integ_enable` never rises.
- Fault priority and latency: in MONITOR, `err_underflow` and `over_threshold` both raised in cycle F → `fault_code`=5 and `shutdown`=1 at F+1. Then `clear_fault` → IDLE with `fault_code`=0 and `shutdown`=0.
- Disarm vs fault: in MONITOR, `disarm` and `err_overflow` in the same cycle → TRIPPED with `fault_code`=4. Plain `disarm` → IDLE and `integ_rst`=1 next cycle.
- Watchdog (macro defined, `SETUP_TIMEOUT`=100): `setup_done` held low → TRIPPED with `fault_code`=2 exactly 100 cycles after entering WAIT_SETUP. With the macro undefined, the block stays in WAIT_SETUP for 10000 cycles.
- Mid-operation reset: `rst` in MONITOR → all outputs at reset values next cycle. A config change while armed leaves `window` unchanged.
